// File: rtl/mul_sign_ctrl.sv
// mul_sign_ctrl: front-end for the 4-cycle unsigned multiplier. It converts
// signed operands to magnitudes, sequences start/done, sign-corrects the
// 64-bit product and returns the selected half over a valid/ready handshake.
// Optional build macro: MUL_FUSE_EN keeps the last completed product so that
// a repeated request on the same operands finishes without the multiplier.
//
// state   | meaning
// ST_IDLE | ready_o high, waiting for a request
// ST_WAIT | multiplier running, start and operands held stable
// ST_RESP | result valid, waiting for ready_i
module mul_sign_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  output logic              mul_start_o,
  input  logic [2*XLEN-1:0] mul_product_i,
  input  logic              mul_done_i
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic [XLEN-1:0]   mul_a_q, mul_a_d;
  logic [XLEN-1:0]   mul_b_q, mul_b_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand signedness and magnitudes; 0x8000_0000 negates to itself, which
  // is the correct unsigned magnitude.
  logic              rs1_signed, rs2_signed;
  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;

  assign rs1_signed = (op_i != OP_MULHU);
  assign rs2_signed = (op_i == OP_MUL) || (op_i == OP_MULH);
  assign rs1_neg    = rs1_signed & rs1_i[XLEN-1];
  assign rs2_neg    = rs2_signed & rs2_i[XLEN-1];
  assign rs1_mag    = rs1_neg ? -rs1_i : rs1_i;
  assign rs2_mag    = rs2_neg ? -rs2_i : rs2_i;

  // Sign correction of the unsigned product and half selection.
  logic              prod_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   prod_sel;

  assign prod_neg = sign1_q ^ sign2_q;
  assign prod_fix = prod_neg ? -mul_product_i : mul_product_i;
  assign prod_sel = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

  logic              hit;
  logic [XLEN-1:0]   hit_result;

`ifdef MUL_FUSE_EN
  logic [XLEN-1:0]   req_rs1_q, req_rs2_q;
  logic              cache_vld_q;
  logic [2*XLEN-1:0] cache_prod_q;
  logic [XLEN-1:0]   cache_rs1_q, cache_rs2_q;
  logic [1:0]        cache_op_q;

  // The low half is the same for every signedness, so MUL hits on any cached op.
  assign hit = cache_vld_q && (rs1_i == cache_rs1_q) && (rs2_i == cache_rs2_q) &&
               ((op_i == OP_MUL) || (op_i == cache_op_q));
  assign hit_result = (op_i == OP_MUL) ? cache_prod_q[XLEN-1:0]
                                       : cache_prod_q[2*XLEN-1:XLEN];

  // Keep the raw operands of the accepted request for the cache tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rs1_q <= '0;
      req_rs2_q <= '0;
    end else if ((state_q == ST_IDLE) && valid_i && !flush_i) begin
      req_rs1_q <= rs1_i;
      req_rs2_q <= rs2_i;
    end
  end

  // Record each completed multiply; a flush invalidates and wins over a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q  <= 1'b0;
      cache_prod_q <= '0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_op_q   <= OP_MUL;
    end else if (flush_i) begin
      cache_vld_q  <= 1'b0;
    end else if ((state_q == ST_WAIT) && mul_done_i) begin
      cache_vld_q  <= 1'b1;
      cache_prod_q <= prod_fix;
      cache_rs1_q  <= req_rs1_q;
      cache_rs2_q  <= req_rs2_q;
      cache_op_q   <= op_q;
    end
  end
`else
  assign hit        = 1'b0;
  assign hit_result = '0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
    end
  end

  // Next state and register updates; flush overrides everything, including an accept.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            op_d    = op_i;
            sign1_d = rs1_neg;
            sign2_d = rs2_neg;
            if (hit) begin
              result_d = hit_result;
              state_d  = ST_RESP;
            end else begin
              mul_a_d = rs1_mag;
              mul_b_d = rs2_mag;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mul_done_i) begin
            result_d = prod_sel;
            state_d  = ST_RESP;
          end
        end
        ST_RESP: begin
          if (ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign valid_o     = (state_q == ST_RESP);
  assign mul_start_o = (state_q == ST_WAIT);
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign result_o    = result_q;

endmodule
